// File: rtl/clock_cpu_ctrl.sv
// Run-time controllable Hack CPU clock generator.
// Free-run, single-step and halt modes with a rise strobe and cycle count.
module clock_cpu_ctrl #(
  parameter int          CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 2500000,
  parameter int          CYC_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] div,
  input  logic [1:0]       mode,
  input  logic             step,
  output logic             clk_cpu,
  output logic             clk_cpu_rise,
  output logic             busy,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [1:0] M_RUN  = 2'b01;
  localparam logic [1:0] M_STEP = 2'b10;

  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);

  // bit 0 is the CPU clock itself, so clk_cpu comes straight off a flop
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    LOW  = 2'b10
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [CNT_W-1:0] div_l, div_l_nx;
  logic             step_q;
  logic             rise_q, rise_nx;
  logic             run, start, hit;

  assign run   = (mode == M_RUN);
  assign start = run | ((mode == M_STEP) & step & ~step_q);
  assign hit   = (cnt == div_l);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_l_nx = div_l;
    rise_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = HIGH;
          cnt_nx   = '0;
          div_l_nx = div;
          rise_nx  = 1'b1;
        end
      end
      HIGH: begin
        if (hit) begin
          state_nx = LOW;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (hit) begin
          cnt_nx = '0;
          if (run) begin
            state_nx = HIGH;
            div_l_nx = div;
            rise_nx  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_l       <= DIV_INIT;
      step_q      <= 1'b0;
      rise_q      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      div_l  <= div_l_nx;
      step_q <= step;
      rise_q <= rise_nx;
      if (rise_nx) cycle_count <= cycle_count + CYC_ONE;
    end
  end

  assign clk_cpu      = state[0];
  assign busy         = (state != IDLE);
  assign clk_cpu_rise = rise_q;

endmodule
